cpu_clock_controller: RTL and testbench



---
 rtl/cpu_clock_controller.sv | 155 +++++++++++++++
 tb/tb_cpu_clock_controller.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_clock_controller.sv
// cpu_clock_controller: 50% duty CPU clock from MCLK with run-time divide ratio.
// Define CPU_CLOCK_STEP_EN to enable counted single-step runs from STOPPED.
module cpu_clock_controller #(
  parameter int DIV_WIDTH = 16,
  parameter logic [DIV_WIDTH-1:0] DEFAULT_DIV = '0
) (
  input  logic                 MCLK_IN,
  input  logic                 RST_N_IN,
  input  logic [DIV_WIDTH-1:0] DIV_IN,
  input  logic                 DIV_WR_IN,
  output logic                 DIV_BUSY_OUT,
  output logic [DIV_WIDTH-1:0] CUR_DIV_OUT,
  input  logic                 RUN_IN,
  input  logic                 STEP_IN,
  input  logic [7:0]           STEP_COUNT_IN,
  output logic                 CPUCLK_OUT,
  output logic                 CPUCLK_RISE_OUT,
  output logic                 CPUCLK_FALL_OUT,
  output logic                 STOPPED_OUT
);

  typedef enum logic [1:0] {
    ST_STOPPED,
    ST_HIGH,
    ST_LOW
  } state_t;

  state_t               state_q, state_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] cur_q, cur_d;
  logic [DIV_WIDTH-1:0] pend_q, pend_d;
  logic                 busy_q, busy_d;
  logic                 clk_q, clk_d;
  logic                 rise_q, rise_d;
  logic                 fall_q, fall_d;
  logic [7:0]           step_q, step_d;
  logic [DIV_WIDTH-1:0] eff_div;
  logic                 go;
  logic                 apply;

`ifndef CPU_CLOCK_STEP_EN
  logic unused_step;
  assign unused_step = ^{STEP_IN, STEP_COUNT_IN};
`endif

  always_ff @(posedge MCLK_IN) begin
    if (!RST_N_IN) begin
      state_q <= ST_STOPPED;
      cnt_q   <= '0;
      cur_q   <= DEFAULT_DIV;
      pend_q  <= '0;
      busy_q  <= 1'b0;
      clk_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cur_q   <= cur_d;
      pend_q  <= pend_d;
      busy_q  <= busy_d;
      clk_q   <= clk_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      step_q  <= step_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cur_d   = cur_q;
    pend_d  = pend_q;
    busy_d  = busy_q;
    clk_d   = clk_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    step_d  = step_q;
    apply   = 1'b0;
    go      = RUN_IN || (step_q != '0);
    // a new period starts with the ratio that is being applied right now
    eff_div = busy_q ? pend_q : cur_q;

    unique case (state_q)
      ST_STOPPED: begin
        apply = 1'b1;
        clk_d = 1'b0;
        if (go) begin
          state_d = ST_HIGH;
          clk_d   = 1'b1;
          rise_d  = 1'b1;
          cnt_d   = eff_div;
        end
      end
      ST_HIGH: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = ST_LOW;
          clk_d   = 1'b0;
          fall_d  = 1'b1;
          cnt_d   = cur_q;
        end
      end
      ST_LOW: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          apply = 1'b1;
          if (go) begin
            state_d = ST_HIGH;
            clk_d   = 1'b1;
            rise_d  = 1'b1;
            cnt_d   = eff_div;
          end else begin
            state_d = ST_STOPPED;
          end
        end
      end
      default: begin
        state_d = ST_STOPPED;
        clk_d   = 1'b0;
      end
    endcase

    if (apply && busy_q) begin
      cur_d  = pend_q;
      busy_d = 1'b0;
    end
    if (DIV_WR_IN) begin
      pend_d = DIV_IN;
      busy_d = 1'b1;
    end

`ifdef CPU_CLOCK_STEP_EN
    if (rise_d && step_q != '0) begin
      step_d = step_q - 8'd1;
    end else if (state_q == ST_STOPPED && !RUN_IN && STEP_IN &&
                 STEP_COUNT_IN != '0 && step_q == '0) begin
      step_d = STEP_COUNT_IN;
    end
`else
    step_d = '0;
`endif
  end

  assign CPUCLK_OUT      = clk_q;
  assign CPUCLK_RISE_OUT = rise_q;
  assign CPUCLK_FALL_OUT = fall_q;
  assign STOPPED_OUT     = (state_q == ST_STOPPED);
  assign DIV_BUSY_OUT    = busy_q;
  assign CUR_DIV_OUT     = cur_q;

endmodule

// File: tb/tb_cpu_clock_controller.sv
// tb_cpu_clock_controller: directed stimulus, phase-age reference model
// checked every cycle, plus literal phase-length and pulse-count checks.
module tb_cpu_clock_controller;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] div = '0;
  logic         wr = 1'b0;
  logic         busy;
  logic [W-1:0] cur;
  logic         run = 1'b0;
  logic         step = 1'b0;
  logic [7:0]   scount = '0;
  logic         cpuclk, rise, fall, stopped;

  always #5 clk = ~clk;

  cpu_clock_controller #(.DIV_WIDTH(W), .DEFAULT_DIV(16'd0)) dut (
    .MCLK_IN(clk),
    .RST_N_IN(rst_n),
    .DIV_IN(div),
    .DIV_WR_IN(wr),
    .DIV_BUSY_OUT(busy),
    .CUR_DIV_OUT(cur),
    .RUN_IN(run),
    .STEP_IN(step),
    .STEP_COUNT_IN(scount),
    .CPUCLK_OUT(cpuclk),
    .CPUCLK_RISE_OUT(rise),
    .CPUCLK_FALL_OUT(fall),
    .STOPPED_OUT(stopped)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int rises = 0, falls = 0, busy_falls = 0, run_cyc = 0;
  logic prev_busy = 1'b0;
  bit chk_en = 1'b0;
`ifdef CPU_CLOCK_STEP_EN
  localparam bit STEP_ON = 1'b1;
`else
  localparam bit STEP_ON = 1'b0;
`endif

  // Model: a phase is tracked by its age (cycles already shown) against
  // its length div+1; period boundaries are where ratio/run are consulted.
  typedef struct {
    logic         clk, rise, fall, stopped, busy;
    logic [W-1:0] cur, pend;
    int           steps, age;
  } mst_t;
  mst_t m;

  function automatic mst_t model_next(mst_t s, logic rs, logic rn, logic w,
                                      logic [W-1:0] d, logic st, int sc);
    mst_t n = s;
    bit go, apply, start;
    n.rise = 1'b0;
    n.fall = 1'b0;
    if (!rs) begin
      n.clk = 1'b0; n.stopped = 1'b1; n.busy = 1'b0;
      n.cur = '0; n.pend = '0; n.steps = 0; n.age = 0;
      return n;
    end
    go = rn || (s.steps > 0);
    apply = 1'b0;
    start = 1'b0;
    if (s.stopped) begin
      apply = 1'b1;
      start = go;
    end else if (s.age == int'(s.cur) + 1) begin
      if (s.clk) begin
        n.clk = 1'b0; n.fall = 1'b1; n.age = 1;
      end else begin
        apply = 1'b1;
        start = go;
        if (!go) begin
          n.stopped = 1'b1; n.clk = 1'b0;
        end
      end
    end else begin
      n.age = s.age + 1;
    end
    if (apply && s.busy) begin
      n.cur = s.pend; n.busy = 1'b0;
    end
    if (start) begin
      n.clk = 1'b1; n.rise = 1'b1; n.stopped = 1'b0; n.age = 1;
      if (n.steps > 0) n.steps = n.steps - 1;
    end
    if (w) begin
      n.pend = d; n.busy = 1'b1;
    end
    if (STEP_ON && s.stopped && !rn && st && sc != 0 && s.steps == 0)
      n.steps = sc;
    return n;
  endfunction

  always @(posedge clk)
    m <= model_next(m, rst_n, run, wr, div, step, int'(scount));

  always @(negedge clk) begin
    if (chk_en) begin
      n_cmp++;
      if ({cpuclk, rise, fall, stopped, busy} !==
          {m.clk, m.rise, m.fall, m.stopped, m.busy} || cur !== m.cur) begin
        n_bad++;
        $display("FAIL cycle t=%0t clk/rise/fall/stop/busy=%b cur=%0d want %b cur=%0d",
                 $time, {cpuclk, rise, fall, stopped, busy}, cur,
                 {m.clk, m.rise, m.fall, m.stopped, m.busy}, m.cur);
      end
      if (rise) rises++;
      if (fall) falls++;
      if (!stopped) run_cyc++;
      if (prev_busy && !busy) busy_falls++;
      prev_busy = busy;
    end
  end

  task automatic check(string name, int got, int want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_rise(int bound);
    int k = 0;
    while (!rise && k < bound) begin
      cyc(1);
      k++;
    end
    if (!rise) check("wait_rise_timeout", 0, 1);
  endtask

  task automatic measure(output int hi, output int lo);
    hi = 0;
    lo = 0;
    wait_rise(2000);
    while (cpuclk && hi < 2000) begin
      hi++;
      cyc(1);
    end
    while (!cpuclk && !stopped && lo < 2000) begin
      lo++;
      cyc(1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int hi, lo, r0, f0, b0, c0, st;
    cyc(3);
    chk_en = 1'b1;
    rst_n = 1'b1;
    check("reset_cpuclk", int'(cpuclk), 0);
    check("reset_stopped", int'(stopped), 1);
    check("reset_busy", int'(busy), 0);
    check("reset_cur", int'(cur), 0);

    // free run at div 0
    run = 1'b1;
    cyc(1);
    check("first_rise", int'(rise), 1);
    check("first_stopped", int'(stopped), 0);
    r0 = rises;
    cyc(20);
    check("div0_rises_in_20", rises - r0, 10);

    // switch to div 39 mid-HIGH
    st = 0;
    while (!cpuclk && st < 10) begin
      cyc(1);
      st++;
    end
    div = 16'd39;
    wr = 1'b1;
    cyc(1);
    wr = 1'b0;
    check("busy_after_wr", int'(busy), 1);
    measure(hi, lo);
    check("div39_high", hi, 40);
    check("div39_low", lo, 40);
    check("div39_cur", int'(cur), 39);

    // two writes in one phase, last wins
    div = 16'd199;
    wr = 1'b1;
    cyc(1);
    div = 16'd3;
    cyc(1);
    wr = 1'b0;
    check("busy_pending", int'(busy), 1);
    b0 = busy_falls;
    measure(hi, lo);
    check("div3_high", hi, 4);
    check("div3_low", lo, 4);
    check("div3_cur", int'(cur), 3);
    check("busy_fell_once", busy_falls - b0, 1);

    // drop run one cycle after rise
    cyc(1);
    run = 1'b0;
    f0 = falls;
    r0 = rises;
    st = 0;
    while (!stopped && st < 100) begin
      st++;
      cyc(1);
    end
    check("stop_latency", st, 7);
    cyc(10);
    check("stop_falls", falls - f0, 1);
    check("stop_rises", rises - r0, 0);
    check("stop_cpuclk", int'(cpuclk), 0);
    check("stop_stopped", int'(stopped), 1);

    // ratio write while stopped: busy for exactly one cycle
    div = 16'd39;
    wr = 1'b1;
    cyc(1);
    wr = 1'b0;
    check("stopped_wr_busy", int'(busy), 1);
    cyc(1);
    check("stopped_wr_done", int'(busy), 0);
    check("stopped_wr_cur", int'(cur), 39);

    // reset mid-HIGH with a pending ratio
    run = 1'b1;
    wait_rise(10);
    cyc(5);
    div = 16'd7;
    wr = 1'b1;
    cyc(1);
    wr = 1'b0;
    check("mid_high_clk", int'(cpuclk), 1);
    rst_n = 1'b0;
    run = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    check("rst_cpuclk", int'(cpuclk), 0);
    check("rst_cur", int'(cur), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_stopped", int'(stopped), 1);
    r0 = rises;
    cyc(5);
    check("rst_no_rise", rises - r0, 0);

    // counted step at div 1
    div = 16'd1;
    wr = 1'b1;
    cyc(1);
    wr = 1'b0;
    cyc(1);
    r0 = rises;
    c0 = run_cyc;
    step = 1'b1;
    scount = 8'd3;
    cyc(1);
    step = 1'b0;
    scount = 8'd0;
    cyc(30);
    check("step_rises", rises - r0, STEP_ON ? 3 : 0);
    check("step_cycles", run_cyc - c0, STEP_ON ? 12 : 0);
    check("step_stopped", int'(stopped), 1);

    cyc(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
